gcd_job_sequencer: RTL and testbench
====================================

# gcd_job_sequencer

Batch front-end for the GCD datapath/control pair (`GDP`). It reads operand pairs from a 16×8 single-port RAM and drives `n1`/`n2` and the active-low `start` into `GDP`. It then waits for `done`, writes `Sum` back into the RAM and pulses the active-low `restart`, repeating for a fixed number of jobs. Operand pairs containing a zero are resolved locally and never launched, because the subtractive GCD does not terminate on a zero operand.

## Interface
- `NJOBS`, default 5: jobs per batch, range 1..5.
- `RES_BASE`, default 10: RAM address of job 0's result.
- `TIMEOUT`, default 1000: maximum WAIT cycles per job before fault, range 1..65535.
- `clk`  in  1  rising-edge clock for all logic.
- `rst_n`  in  1  synchronous reset, active-low.
- `go`  in  1  start-batch request, sampled at each edge.
- `busy`  out  1  batch in progress.
- `all_done`  out  1  batch finished without fault; sticky until next `go` or reset.
- `err`  out  1  timeout fault; sticky until reset.
- `job_idx`  out  3  current job number, 0..NJOBS-1.
- `ram_addr`  out  4  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  8  RAM write data.
- `ram_rdata`  in  8  RAM read data, combinational from `ram_addr`.
- `gcd_n1`, `gcd_n2`  out  8  operands to `GDP` `n1`/`n2`.
- `gcd_start_n`  out  1  to `GDP` `start`, active-low.
- `gcd_restart_n`  out  1  to `GDP` `restart`, active-low.
- `gcd_done`  in  1  from `GDP` `done`.
- `gcd_sum`  in  8  from `GDP` `Sum`; valid only while `gcd_done`=1.

## Operation
- Memory layout: job k uses operand A at address 2k, operand B at address 2k+1, and writes its result to address RES_BASE+k.
- All address arithmetic is 4-bit.
- FSM states: IDLE, FLUSH, RD_A, RD_B, CHECK, LAUNCH, WAIT, WRITE, RELEASE, DONE, FAULT.
- IDLE / DONE:
  - On `go`=1, clear `all_done`, set `job_idx`=0 and `busy`=1.
  - Go to FLUSH if `gcd_done`=1 (`GDP` left stale in its done state, since `GDP` has no reset); otherwise go to RD_A.
- FLUSH: `gcd_restart_n`=0 for one cycle, then RD_A.
- RD_A: `ram_addr`=2·job_idx; register `ram_rdata` into opA; go to RD_B.
- RD_B: `ram_addr`=2·job_idx+1; register into opB; go to CHECK.
- CHECK:
  - If opA==0 or opB==0: result = opA|opB (gcd(x,0)=x, gcd(0,0)=0); go to WRITE.
  - Otherwise: go to LAUNCH.
- LAUNCH: `gcd_n1`=opA, `gcd_n2`=opB, `gcd_start_n`=0 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - `gcd_n1`/`gcd_n2` are held stable throughout.
  - Counter increments every cycle.
  - If `gcd_done`=1: register `gcd_sum` as result, go to WRITE. `gcd_done` takes priority over timeout in the same cycle.
  - Else if counter == TIMEOUT-1: set `err`=1, go to FAULT.
- WRITE: `ram_addr`=RES_BASE+job_idx, `ram_we`=1, `ram_wdata`=result for one cycle; go to RELEASE.
- RELEASE:
  - `gcd_restart_n`=0 for one cycle. This is harmless on skipped jobs because `GDP` ignores `restart` outside its done state.
  - If job_idx==NJOBS-1: `busy`=0, `all_done`=1, go to DONE.
  - Else: job_idx+1, go to RD_A.
- FAULT: `busy`=0, all strobes inactive, `go` ignored; only `rst_n` exits.
- `go` is ignored while `busy`=1.

## Timing
- Reset values, applied at the first edge with `rst_n`=0:
  - state IDLE; `busy`=`all_done`=`err`=0; `job_idx`=0.
  - `ram_addr`=0, `ram_we`=0, `ram_wdata`=0.
  - `gcd_n1`=`gcd_n2`=0; `gcd_start_n`=`gcd_restart_n`=1.
- All outputs are registered or decoded from state only; no combinational paths from inputs to outputs.
- Per-job latency:
  - Skipped (zero-operand) job: 5 cycles (RD_A, RD_B, CHECK, WRITE, RELEASE).
  - Launched job: 6 cycles + W, where W is the number of WAIT cycles up to and including the cycle in which `gcd_done` is first seen.
- `gcd_start_n` low for exactly one cycle per launched job; `gcd_restart_n` low for exactly one cycle per job, plus one extra cycle for FLUSH when it occurs.
- `ram_we` high for exactly one cycle per job; never high in FAULT.
- Reset mid-batch: all outputs return to reset values at the next edge. Any stale `GDP` done state is cleared by the FLUSH on the next `go`.

## Test plan
- Reset, then hold `go`=0 for 20 cycles -> all outputs keep their reset values; state stays IDLE.
- NJOBS=1, mem[0]=12, mem[1]=18, with a real `GDP` -> exactly one `gcd_start_n` pulse; mem[10]=6 after WRITE; one `gcd_restart_n` pulse; `all_done`=1, `busy`=0.
- NJOBS=2, pairs (0,9) and (0,0) -> no `gcd_start_n` pulse; mem[10]=9, mem[11]=0; 10 cycles from `go` to `all_done`.
- NJOBS=5, pairs (12,18), (7,7), (35,14), (1,200), (255,85) -> mem[10..14] = 6, 7, 7, 1, 85; `job_idx` steps 0..4; `go` pulsed mid-batch has no effect.
- TIMEOUT=20, `GDP` replaced by a model that never asserts `gcd_done` -> `err`=1 after 20 WAIT cycles; no RAM write; `busy`=0; subsequent `go` ignored until `rst_n`.
- `rst_n` low during WAIT of job 2, then `go` while `gcd_done`=1 -> reset values on the next edge; FLUSH restart pulse precedes RD_A; batch then completes with correct results.

Source files
------------

// File: rtl/gcd_job_sequencer.sv
// Batch front-end for the subtractive GCD datapath: fetches operand pairs from RAM,
// launches the GCD unit, waits for done and writes each result back.
module gcd_job_sequencer #(
    parameter int NJOBS    = 5,
    parameter int RES_BASE = 10,
    parameter int TIMEOUT  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    output logic       busy,
    output logic       all_done,
    output logic       err,
    output logic [2:0] job_idx,
    output logic [3:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic [7:0] gcd_n1,
    output logic [7:0] gcd_n2,
    output logic       gcd_start_n,
    output logic       gcd_restart_n,
    input  logic       gcd_done,
    input  logic [7:0] gcd_sum
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FLUSH,
        S_RD_A,
        S_RD_B,
        S_CHECK,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_RELEASE,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [2:0]  LAST_JOB   = 3'(NJOBS - 1);
    localparam logic [3:0]  RES_BASE4  = 4'(RES_BASE);
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

    state_t      state_reg;
    logic [7:0]  op_a_reg;
    logic [7:0]  op_b_reg;
    logic [15:0] wait_cnt_reg;

    // Every output is loaded on the transition into the state that owns it,
    // so the outputs seen during a state are plain flops with no input paths.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            busy          <= 1'b0;
            all_done      <= 1'b0;
            err           <= 1'b0;
            job_idx       <= '0;
            ram_addr      <= '0;
            ram_we        <= 1'b0;
            ram_wdata     <= '0;
            gcd_n1        <= '0;
            gcd_n2        <= '0;
            gcd_start_n   <= 1'b1;
            gcd_restart_n <= 1'b1;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            wait_cnt_reg  <= '0;
        end else begin
            ram_we        <= 1'b0;
            gcd_start_n   <= 1'b1;
            gcd_restart_n <= 1'b1;

            unique case (state_reg)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        all_done <= 1'b0;
                        busy     <= 1'b1;
                        job_idx  <= '0;
                        // The GCD unit has no reset and may still sit in its done state.
                        if (gcd_done) begin
                            state_reg     <= S_FLUSH;
                            gcd_restart_n <= 1'b0;
                        end else begin
                            state_reg <= S_RD_A;
                            ram_addr  <= 4'd0;
                        end
                    end
                end
                S_FLUSH: begin
                    state_reg <= S_RD_A;
                    ram_addr  <= {job_idx, 1'b0};
                end
                S_RD_A: begin
                    op_a_reg  <= ram_rdata;
                    ram_addr  <= {job_idx, 1'b1};
                    state_reg <= S_RD_B;
                end
                S_RD_B: begin
                    op_b_reg  <= ram_rdata;
                    state_reg <= S_CHECK;
                end
                S_CHECK: begin
                    // A zero operand would never terminate the subtractive GCD.
                    if (op_a_reg == 8'd0 || op_b_reg == 8'd0) begin
                        state_reg <= S_WRITE;
                        ram_addr  <= RES_BASE4 + {1'b0, job_idx};
                        ram_we    <= 1'b1;
                        ram_wdata <= op_a_reg | op_b_reg;
                    end else begin
                        state_reg   <= S_LAUNCH;
                        gcd_n1      <= op_a_reg;
                        gcd_n2      <= op_b_reg;
                        gcd_start_n <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    if (gcd_done) begin
                        state_reg <= S_WRITE;
                        ram_addr  <= RES_BASE4 + {1'b0, job_idx};
                        ram_we    <= 1'b1;
                        ram_wdata <= gcd_sum;
                    end else if (wait_cnt_reg == WAIT_LIMIT) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_FAULT;
                    end
                end
                S_WRITE: begin
                    gcd_restart_n <= 1'b0;
                    state_reg     <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (job_idx == LAST_JOB) begin
                        busy      <= 1'b0;
                        all_done  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        job_idx   <= job_idx + 3'd1;
                        ram_addr  <= {job_idx + 3'd1, 1'b0};
                        state_reg <= S_RD_A;
                    end
                end
                S_FAULT: begin
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Randomized bench for gcd_job_sequencer: RAM and GCD-unit models, a per-cycle
// expected-output trace derived from the job rules, and final RAM checks.
`timescale 1ns/1ps
module tb_gcd_job_sequencer;

    localparam int NJOBS    = 5;
    localparam int RES_BASE = 10;
    localparam int TIMEOUT  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       busy, all_done, err;
    logic [2:0] job_idx;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata, ram_rdata, gcd_n1, gcd_n2, gcd_sum;
    logic       gcd_start_n, gcd_restart_n, gcd_done;

    always #5 clk = ~clk;

    gcd_job_sequencer #(.NJOBS(NJOBS), .RES_BASE(RES_BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .all_done(all_done), .err(err),
        .job_idx(job_idx), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .gcd_n1(gcd_n1), .gcd_n2(gcd_n2), .gcd_start_n(gcd_start_n),
        .gcd_restart_n(gcd_restart_n), .gcd_done(gcd_done), .gcd_sum(gcd_sum)
    );

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // RAM model: bench preloads through load_req, the DUT writes through ram_we.
    logic [7:0] mem [16];
    logic [7:0] mem_init [16];
    logic [7:0] exp_mem [16];
    logic       load_req = 1'b0;
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (load_req) mem <= mem_init;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    // GCD unit model: no reset, fixed latency per job, holds done until restart.
    int         lat_pick [NJOBS];
    bit         hang = 1'b0;
    bit         gdp_kick = 1'b0;
    int         g_st = 0;
    int         g_cnt = 0;
    logic [7:0] g_res = 8'd0;
    logic [7:0] junk = 8'd0;
    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (gdp_kick) g_st <= 0;
        else case (g_st)
            0: if (!gcd_start_n) begin
                g_res <= 8'(gcd_ref(int'(gcd_n1), int'(gcd_n2)));
                g_cnt <= lat_pick[job_idx];
                g_st  <= 1;
            end
            1: if (!hang) begin
                if (g_cnt <= 1) g_st <= 2;
                else g_cnt <= g_cnt - 1;
            end
            default: if (!gcd_restart_n) g_st <= 0;
        endcase
    end
    assign gcd_done = (g_st == 2);
    assign gcd_sum  = gcd_done ? g_res : junk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        bit       busy, all_done, err;
        bit [2:0] job;
        bit       we, start_n, restart_n;
        bit [3:0] addr;
        bit [7:0] wdata, n1, n2;
        bit       ca, cw, cn;
    } exp_t;

    exp_t exp_q[$];
    exp_t rest;
    bit   rest_valid = 1'b0;
    int   rd_i = 0;
    int   tr_cyc = 0;
    int   go_edge = 0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] plan_res [5] = '{8'd6, 8'd7, 8'd7, 8'd1, 8'd85};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic emit(input exp_t r);
        r.cyc = tr_cyc;
        tr_cyc++;
        exp_q.push_back(r);
    endtask

    // Expected output trace of one batch, cycle by cycle, from the job rules.
    task automatic build_trace(input int t0, input bit flush, input bit hang_mode);
        exp_t d, r;
        int a, b, res;
        tr_cyc = t0;
        exp_mem = mem;
        d = '{default: 0};
        d.busy = 1'b1; d.start_n = 1'b1; d.restart_n = 1'b1;
        if (flush) begin
            r = d; r.restart_n = 1'b0; emit(r);
        end
        for (int k = 0; k < NJOBS; k++) begin
            a = int'(mem[2*k]);
            b = int'(mem[2*k+1]);
            r = d; r.job = 3'(k); r.addr = 4'(2*k); r.ca = 1'b1; emit(r);
            r.addr = 4'(2*k+1); emit(r);
            r = d; r.job = 3'(k); emit(r);
            if (a != 0 && b != 0) begin
                r.start_n = 1'b0; r.n1 = 8'(a); r.n2 = 8'(b); r.cn = 1'b1; emit(r);
                r.start_n = 1'b1;
                if (hang_mode) begin
                    repeat (TIMEOUT) emit(r);
                    r = d; r.busy = 1'b0; r.err = 1'b1; r.job = 3'(k); emit(r);
                    return;
                end
                repeat (lat_pick[k] + 1) emit(r);
                res = gcd_ref(a, b);
            end else begin
                res = a | b;
            end
            r = d; r.job = 3'(k); r.addr = 4'(RES_BASE + k); r.ca = 1'b1;
            r.we = 1'b1; r.wdata = 8'(res); r.cw = 1'b1; emit(r);
            exp_mem[RES_BASE + k] = 8'(res);
            r = d; r.job = 3'(k); r.restart_n = 1'b0; emit(r);
        end
        r = d; r.busy = 1'b0; r.all_done = 1'b1; r.job = 3'(NJOBS - 1); emit(r);
    endtask

    task automatic compare_loop();
        logic [36:0] a, x, m;
        forever begin
            @(negedge clk);
            if (rd_i < exp_q.size() && exp_q[rd_i].cyc <= cyc) begin
                rest = exp_q[rd_i];
                rd_i++;
                rest_valid = 1'b1;
            end
            if (rest_valid) begin
                a = {busy, all_done, err, job_idx, ram_we, gcd_start_n, gcd_restart_n,
                     ram_addr, ram_wdata, gcd_n1, gcd_n2};
                x = {rest.busy, rest.all_done, rest.err, rest.job, rest.we, rest.start_n,
                     rest.restart_n, rest.addr, rest.wdata, rest.n1, rest.n2};
                m = {9'h1FF, {4{rest.ca}}, {8{rest.cw}}, {16{rest.cn}}};
                checks++;
                if (((a ^ x) & m) != '0) begin
                    failures++;
                    $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h care=%h",
                             cyc, a, x, m);
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        exp_t r;
        @(posedge clk); #1;
        rst_n = 1'b0;
        while (exp_q.size() > rd_i && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        r = '{default: 0};
        r.start_n = 1'b1; r.restart_n = 1'b1; r.ca = 1'b1; r.cw = 1'b1; r.cn = 1'b1;
        r.cyc = cyc + 1;
        exp_q.push_back(r);
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_mem();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic set_pair(input int k, input int a, input int b, input int lat);
        mem_init[2*k]   = 8'(a);
        mem_init[2*k+1] = 8'(b);
        lat_pick[k]     = lat;
    endtask

    task automatic start_batch(input bit hang_mode);
        @(posedge clk); #1;
        go = 1'b1;
        hang = hang_mode;
        go_edge = cyc + 1;
        build_trace(cyc + 1, gcd_done, hang_mode);
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (rd_i < exp_q.size() && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (rd_i < exp_q.size()) chk({name, "_drain_timeout"}, n, -1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_ram(input string name);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_ram%0d", name, i), int'(mem[i]), int'(exp_mem[i]));
        $display("batch %s: ram checked, results %0d %0d %0d %0d %0d", name,
                 mem[RES_BASE], mem[RES_BASE+1], mem[RES_BASE+2], mem[RES_BASE+3], mem[RES_BASE+4]);
    endtask

    task automatic run_tests();
        int n;
        for (int i = 0; i < 16; i++) mem_init[i] = 8'd0;
        for (int k = 0; k < NJOBS; k++) lat_pick[k] = 1;
        load_mem();
        do_reset(3);
        repeat (20) @(posedge clk);
        chk("model_gcd_12_18", gcd_ref(12, 18), 6);
        chk("model_gcd_255_85", gcd_ref(255, 85), 85);
        chk("model_gcd_35_14", gcd_ref(35, 14), 7);
        chk("model_gcd_1_200", gcd_ref(1, 200), 1);

        // Reference batch with a go pulse while busy.
        set_pair(0, 12, 18, 3); set_pair(1, 7, 7, 1); set_pair(2, 35, 14, 7);
        set_pair(3, 1, 200, 12); set_pair(4, 255, 85, 5);
        load_mem();
        start_batch(1'b0);
        repeat (8) @(posedge clk);
        pulse_go();
        wait_drain("plan");
        for (int k = 0; k < 5; k++) chk($sformatf("plan_result%0d", k), int'(mem[RES_BASE+k]), int'(plan_res[k]));
        check_ram("plan");

        // All jobs skipped: five jobs of five cycles each.
        set_pair(0, 0, 9, 1); set_pair(1, 0, 0, 1); set_pair(2, 5, 0, 1);
        set_pair(3, 0, 0, 1); set_pair(4, 0, 255, 1);
        load_mem();
        start_batch(1'b0);
        n = 0;
        while (!all_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("zero_batch_latency", cyc - go_edge, 25);
        wait_drain("zero");
        chk("zero_result0", int'(mem[RES_BASE]), 9);
        chk("zero_result1", int'(mem[RES_BASE+1]), 0);
        check_ram("zero");

        // Done seen on the very cycle the timeout would fire, and one before.
        set_pair(0, 200, 3, TIMEOUT - 1); set_pair(1, 48, 36, TIMEOUT - 2);
        set_pair(2, 9, 6, 1); set_pair(3, 100, 75, TIMEOUT - 1); set_pair(4, 17, 51, 2);
        load_mem();
        start_batch(1'b0);
        wait_drain("boundary");
        check_ram("boundary");

        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < NJOBS; k++)
                set_pair(k, ($urandom_range(3) == 0) ? 0 : int'($urandom_range(255, 1)),
                         ($urandom_range(3) == 0) ? 0 : int'($urandom_range(255, 1)),
                         int'($urandom_range(TIMEOUT - 1, 1)));
            load_mem();
            start_batch(1'b0);
            wait_drain("random");
            check_ram($sformatf("random%0d", it));
        end

        // GCD unit that never finishes: fault, no write, go ignored afterwards.
        set_pair(0, 0, 3, 1); set_pair(1, 9, 6, 1);
        load_mem();
        start_batch(1'b1);
        wait_drain("hang");
        pulse_go();
        repeat (5) @(posedge clk);
        pulse_go();
        repeat (5) @(posedge clk);
        check_ram("hang");
        do_reset(2);
        @(posedge clk); #1 gdp_kick = 1'b1; hang = 1'b0;
        @(posedge clk); #1 gdp_kick = 1'b0;

        // Reset during the WAIT of job 2, then restart with the unit stuck in done.
        set_pair(0, 30, 45, 2); set_pair(1, 64, 48, 3); set_pair(2, 81, 27, 15);
        set_pair(3, 13, 26, 4); set_pair(4, 99, 33, 1);
        load_mem();
        start_batch(1'b0);
        n = 0;
        while (!(job_idx == 3'd2 && gcd_start_n == 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("job2_launch_seen", int'(job_idx == 3'd2 && gcd_start_n == 1'b0), 1);
        repeat (3) @(posedge clk);
        do_reset(2);
        n = 0;
        while (!gcd_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("stale_done_present", int'(gcd_done), 1);
        for (int k = 0; k < NJOBS; k++) lat_pick[k] = int'($urandom_range(TIMEOUT - 1, 1));
        start_batch(1'b0);
        wait_drain("flush");
        check_ram("flush");
    endtask

    initial begin
        fork
            compare_loop();
            run_tests();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
